// File: rtl/xc_malu_pkg.sv
// xc_malu_pkg: shared constants and state encoding for the malu sequential units
package xc_malu_pkg;
  localparam int XLEN = 32;
  localparam int MULSEQ_CW = 6;
  typedef enum logic [1:0] {
    MULSEQ_IDLE = 2'd0,
    MULSEQ_RUN  = 2'd1,
    MULSEQ_DONE = 2'd2
  } mulseq_state_e;
endpackage

// File: rtl/xc_malu_mulseq_if.sv
// xc_malu_mulseq_if: request/response bundle between the malu issue logic and the multiplier
interface xc_malu_mulseq_if;
  import xc_malu_pkg::*;
  logic                 valid;
  logic                 flush;
  logic [XLEN-1:0]      rs1;
  logic [XLEN-1:0]      rs2;
  logic                 op_lhs_signed;
  logic                 op_rhs_signed;
  logic                 op_high;
  logic                 busy;
  logic                 ready;
  logic [XLEN-1:0]      result;
  logic [MULSEQ_CW-1:0] count;
  modport master (
    output valid, flush, rs1, rs2, op_lhs_signed, op_rhs_signed, op_high,
    input  busy, ready, result, count
  );
  modport slave (
    input  valid, flush, rs1, rs2, op_lhs_signed, op_rhs_signed, op_high,
    output busy, ready, result, count
  );
endinterface

// File: rtl/xc_malu_mulseq_step.sv
// xc_malu_mulseq_step: one add/subtract-and-shift step of the radix-2 multiplier
// XC_MALU_MULSEQ_EARLY_EXIT_EN: also detects an all-zero remaining multiplier and finishes in one shift
module xc_malu_mulseq_step import xc_malu_pkg::*; (
  input  logic [XLEN:0]          hi,
  input  logic [XLEN-1:0]        lo,
  input  logic [XLEN:0]          mcand,
  input  logic                   sub,
  input  logic [MULSEQ_CW-1:0]   count,
  input  logic                   rhs_signed,
  output logic [XLEN:0]          hi_n,
  output logic [XLEN-1:0]        lo_n,
  output logic                   early
);
  logic [XLEN:0]   addend;
  logic [XLEN+1:0] sum;
  assign addend = lo[0] ? mcand : '0;
  // one guard bit keeps an unsigned carry out of hi from being shifted back in as a sign
  assign sum = sub ? {hi[XLEN], hi} - {addend[XLEN], addend}
                   : {hi[XLEN], hi} + {addend[XLEN], addend};
`ifdef XC_MALU_MULSEQ_EARLY_EXIT_EN
  logic [2*XLEN:0] acc_sh;
  logic [XLEN-1:0] rest;
  assign rest   = lo & ({XLEN{1'b1}} >> count);
  assign early  = ~|rest & ~(rhs_signed & (count == MULSEQ_CW'(XLEN - 1)));
  assign acc_sh = $signed({hi, lo}) >>> (MULSEQ_CW'(XLEN) - count);
  assign hi_n   = early ? acc_sh[2*XLEN:XLEN] : sum[XLEN+1:1];
  assign lo_n   = early ? acc_sh[XLEN-1:0] : {sum[0], lo[XLEN-1:1]};
`else
  logic unused_early_inputs;
  assign unused_early_inputs = ^{count, rhs_signed};
  assign early = 1'b0;
  assign hi_n  = sum[XLEN+1:1];
  assign lo_n  = {sum[0], lo[XLEN-1:1]};
`endif
endmodule

// File: rtl/xc_malu_mulseq.sv
// xc_malu_mulseq: sequential shift-add multiplier (mul/mulh/mulhsu/mulhu) for the multi-cycle ALU
// XC_MALU_MULSEQ_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero
module xc_malu_mulseq import xc_malu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            resetn,
  xc_malu_mulseq_if.slave bus
);
  if (XLEN != 32) begin : g_xlen_bad
    $error("xc_malu_mulseq: only XLEN=32 is supported");
  end
  mulseq_state_e        state_q, state_d;
  logic [XLEN:0]        hi_q, hi_d, mcand_q, mcand_d, hi_n;
  logic [XLEN-1:0]      lo_q, lo_d, lo_n, result_q, result_d;
  logic [MULSEQ_CW-1:0] count_q, count_d;
  logic                 rhs_signed_q, rhs_signed_d, high_q, high_d;
  logic                 busy_q, busy_d, ready_q, ready_d;
  logic                 last, sub, early;
  assign last = count_q == MULSEQ_CW'(XLEN - 1);
  // the multiplier sign bit carries weight -2^31, so its partial product is subtracted
  assign sub  = rhs_signed_q & last;
  xc_malu_mulseq_step u_step (
    .hi         (hi_q),
    .lo         (lo_q),
    .mcand      (mcand_q),
    .sub        (sub),
    .count      (count_q),
    .rhs_signed (rhs_signed_q),
    .hi_n       (hi_n),
    .lo_n       (lo_n),
    .early      (early)
  );
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mcand_d      = mcand_q;
    count_d      = count_q;
    rhs_signed_d = rhs_signed_q;
    high_d       = high_q;
    busy_d       = busy_q;
    ready_d      = ready_q;
    result_d     = result_q;
    if (bus.flush) begin
      state_d  = MULSEQ_IDLE;
      count_d  = '0;
      busy_d   = 1'b0;
      ready_d  = 1'b0;
      result_d = '0;
    end else if (state_q == MULSEQ_IDLE) begin
      count_d = '0;
      if (bus.valid) begin
        state_d      = MULSEQ_RUN;
        busy_d       = 1'b1;
        mcand_d      = {bus.op_lhs_signed & bus.rs1[XLEN-1], bus.rs1};
        hi_d         = '0;
        lo_d         = bus.rs2;
        rhs_signed_d = bus.op_rhs_signed;
        high_d       = bus.op_high;
      end
    end else if (state_q == MULSEQ_RUN) begin
      hi_d    = hi_n;
      lo_d    = lo_n;
      count_d = (early | last) ? MULSEQ_CW'(XLEN) : count_q + 1'b1;
      if (early | last) begin
        state_d  = MULSEQ_DONE;
        busy_d   = 1'b0;
        ready_d  = 1'b1;
        result_d = high_d ? hi_n[XLEN-1:0] : lo_n;
      end
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= MULSEQ_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      mcand_q      <= '0;
      count_q      <= '0;
      rhs_signed_q <= 1'b0;
      high_q       <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mcand_q      <= mcand_d;
      count_q      <= count_d;
      rhs_signed_q <= rhs_signed_d;
      high_q       <= high_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      result_q     <= result_d;
    end
  end
  assign bus.busy   = busy_q;
  assign bus.ready  = ready_q;
  assign bus.result = result_q;
  assign bus.count  = count_q;
endmodule

// File: tb/tb_xc_malu_mulseq.sv
// tb_xc_malu_mulseq: directed vector table plus flush/reset/hold sequences for the multiplier
module tb_xc_malu_mulseq;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;
  xc_malu_mulseq_if bus();
  xc_malu_mulseq dut (.clock(clock), .resetn(resetn), .bus(bus));
  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ls;
    logic        rs;
    logic        high;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [8];
  int checks = 0;
  int passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask
  task automatic run_op(input vec_t v, output logic [31:0] res, output int lat);
    @(negedge clock);
    bus.valid = 1'b1;
    bus.rs1 = v.rs1;
    bus.rs2 = v.rs2;
    bus.op_lhs_signed = v.ls;
    bus.op_rhs_signed = v.rs;
    bus.op_high = v.high;
    lat = 0;
    res = 'x;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      if (e == 1) begin
        bus.rs1 = ~v.rs1;
        bus.rs2 = ~v.rs2;
        bus.op_lhs_signed = ~v.ls;
        bus.op_rhs_signed = ~v.rs;
        bus.op_high = ~v.high;
      end
      if (bus.ready) begin
        lat = e;
        res = bus.result;
        break;
      end
    end
    bus.valid = 1'b0;
  endtask
  task automatic flush_op(input string name);
    @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk({name, "_flush_ready"}, 32'(bus.ready), 32'd0);
    chk({name, "_flush_result"}, bus.result, 32'd0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] res;
    int lat;
    int found;
    int seen;
    vec_t v;
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.op_lhs_signed = 1'b0;
    bus.op_rhs_signed = 1'b0;
    bus.op_high = 1'b0;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    resetn = 1'b1;
    tv[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE};
    tv[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001};
    tv[2] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000};
    tv[3] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000};
    tv[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
    tv[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001};
    tv[6] = '{32'h00000007, 32'hFFFFFFFD, 1'b1, 1'b1, 1'b0, 32'hFFFFFFEB};
    tv[7] = '{32'h00000007, 32'hFFFFFFFD, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) begin
      run_op(tv[i], res, lat);
      chk($sformatf("vec%0d_result", i), res, tv[i].exp);
`ifdef XC_MALU_MULSEQ_EARLY_EXIT_EN
      chk($sformatf("vec%0d_latency_in_range", i), 32'(lat >= 2 && lat <= 33), 32'd1);
`else
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
`endif
      flush_op($sformatf("vec%0d", i));
    end
    v = '{32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd15};
    run_op(v, res, lat);
    repeat (3) @(negedge clock);
    chk("hold_ready", 32'(bus.ready), 32'd1);
    chk("hold_result", bus.result, 32'd15);
    chk("hold_count", 32'(bus.count), 32'd32);
    chk("hold_busy", 32'(bus.busy), 32'd0);
    flush_op("hold");
    @(negedge clock);
    bus.valid = 1'b1;
    bus.flush = 1'b1;
    bus.rs2 = 32'hFFFFFFFF;
    @(posedge clock);
    #1;
    chk("flush_capture_busy", 32'(bus.busy), 32'd0);
    @(negedge clock);
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    @(posedge clock);
    #1;
    chk("flush_capture_idle", 32'(bus.busy), 32'd0);
    @(negedge clock);
    bus.valid = 1'b1;
    bus.rs1 = 32'h00001234;
    bus.rs2 = 32'hFFFFFFFF;
    bus.op_lhs_signed = 1'b0;
    bus.op_rhs_signed = 1'b0;
    bus.op_high = 1'b0;
    found = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock);
      #1;
      if (bus.busy && bus.count == 6'd10) begin
        found = 1;
        break;
      end
    end
    chk("flush_reach_count10", 32'(found), 32'd1);
    chk("run_result_zero", bus.result, 32'd0);
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_count", 32'(bus.count), 32'd0);
    bus.flush = 1'b0;
    bus.valid = 1'b0;
    seen = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock);
      #1;
      if (bus.ready || bus.busy) seen++;
    end
    chk("flush_no_ready", 32'(seen), 32'd0);
    run_op(v, res, lat);
    chk("after_flush_result", res, 32'd15);
`ifndef XC_MALU_MULSEQ_EARLY_EXIT_EN
    chk("after_flush_latency", 32'(lat), 32'd33);
`endif
    flush_op("after_flush");
    @(negedge clock);
    bus.valid = 1'b1;
    bus.rs1 = 32'h00000009;
    bus.rs2 = 32'hFFFFFFFF;
    repeat (5) @(posedge clock);
    #1;
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_ready", 32'(bus.ready), 32'd0);
    chk("async_rst_result", bus.result, 32'd0);
    chk("async_rst_count", 32'(bus.count), 32'd0);
    @(negedge clock);
    bus.valid = 1'b0;
    resetn = 1'b1;
`ifdef XC_MALU_MULSEQ_EARLY_EXIT_EN
    v = '{32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000};
    run_op(v, res, lat);
    chk("early_zero_result", res, 32'd0);
    chk("early_zero_latency", 32'(lat), 32'd2);
    flush_op("early_zero");
    v = '{32'h12345678, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h12345678};
    run_op(v, res, lat);
    chk("early_one_result", res, 32'h12345678);
    chk("early_one_latency_short", 32'(lat >= 2 && lat < 33), 32'd1);
    flush_op("early_one");
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
